// File: rtl/rob_multiport.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rob_multiport: reorder buffer, multi-port writeback, in-order commit,      |
// | branch/JALR flush. Optional ROB_RETIRE_CNT_EN adds a 64-bit retire count. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module rob_multiport #(
  parameter int ROB_W    = 4,
  parameter int WB_PORTS = 2,
  parameter int XLEN     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         issue_valid,
  input  logic [6:0]                   issue_type,
  input  logic [XLEN-1:0]              issue_pc,
  input  logic [4:0]                   issue_rd,
  input  logic [XLEN-1:0]              issue_imm,
  input  logic                         issue_pred_taken,
  input  logic [XLEN-1:0]              issue_pred_target,
  output logic                         rob_full,
  output logic [ROB_W:0]               rob_count,
  output logic [ROB_W-1:0]             alloc_id,
  output logic [ROB_W-1:0]             head_id,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*ROB_W-1:0]    wb_id,
  input  logic [WB_PORTS*XLEN-1:0]     wb_value,
  input  logic [WB_PORTS*XLEN-1:0]     wb_target,
  output logic                         commit_valid,
  output logic [ROB_W-1:0]             commit_id,
  output logic [4:0]                   commit_rd,
  output logic [XLEN-1:0]              commit_value,
  input  logic [ROB_W-1:0]             q_id1,
  input  logic [ROB_W-1:0]             q_id2,
  output logic                         q_ready1,
  output logic                         q_ready2,
  output logic [XLEN-1:0]              q_value1,
  output logic [XLEN-1:0]              q_value2,
  output logic                         flush,
  output logic [XLEN-1:0]              flush_pc,
  output logic [63:0]                  retire_cnt
);

  localparam int         DEPTH      = 1 << ROB_W;
  localparam logic [ROB_W:0] FULL_COUNT = (ROB_W+1)'(DEPTH);
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  e_pred_taken;
  logic [6:0]        e_type        [DEPTH];
  logic [4:0]        e_rd          [DEPTH];
  logic [XLEN-1:0]   e_pc          [DEPTH];
  logic [XLEN-1:0]   e_value       [DEPTH];
  logic [XLEN-1:0]   e_target      [DEPTH];
  logic [XLEN-1:0]   e_pred_target [DEPTH];
  logic [ROB_W-1:0]  head;
  logic [ROB_W-1:0]  tail;
  logic [ROB_W:0]    count;

  logic [ROB_W-1:0]  wbid  [WB_PORTS];
  logic [XLEN-1:0]   wbval [WB_PORTS];
  logic [XLEN-1:0]   wbtgt [WB_PORTS];

  for (genvar k = 0; k < WB_PORTS; k++) begin : g_wb_unpack
    assign wbid[k]  = wb_id[k*ROB_W +: ROB_W];
    assign wbval[k] = wb_value[k*XLEN +: XLEN];
    assign wbtgt[k] = wb_target[k*XLEN +: XLEN];
  end

  // Types whose result is known at decode complete without a writeback.
  logic            issue_instant;
  logic [XLEN-1:0] issue_instant_value;
  always_comb begin
    issue_instant       = 1'b1;
    issue_instant_value = '0;
    case (issue_type)
      OP_LUI:   issue_instant_value = issue_imm;
      OP_AUIPC: issue_instant_value = issue_pc + issue_imm;
      OP_JAL:   issue_instant_value = issue_pc + XLEN'(4);
      default:  issue_instant       = 1'b0;
    endcase
  end

  logic head_is_b, head_is_jalr, head_is_s, head_taken, mispredict;
  logic commit_fire, issue_fire;
  assign head_is_b    = (e_type[head] == OP_BRANCH);
  assign head_is_jalr = (e_type[head] == OP_JALR);
  assign head_is_s    = (e_type[head] == OP_STORE);
  assign head_taken   = e_value[head][0];

  always_comb begin
    mispredict = 1'b0;
    if (head_is_b)
      mispredict = (head_taken != e_pred_taken[head]) ||
                   (head_taken && (e_target[head] != e_pred_target[head]));
    else if (head_is_jalr)
      mispredict = (e_target[head] != e_pred_target[head]);
  end

  assign commit_fire  = rdy && busy[head] && ready[head];
  assign flush        = commit_fire && mispredict;
  assign flush_pc     = !flush ? '0 :
                        (head_is_b && !head_taken) ? e_pc[head] + XLEN'(4) : e_target[head];
  assign rob_full     = (count == FULL_COUNT);
  assign issue_fire   = issue_valid && !rob_full && rdy && !flush;

  assign rob_count    = count;
  assign alloc_id     = tail;
  assign head_id      = head;
  assign commit_valid = commit_fire;
  assign commit_id    = head;
  assign commit_rd    = (commit_fire && !head_is_b && !head_is_s) ? e_rd[head] : 5'd0;
  assign commit_value = commit_fire ? e_value[head] : '0;

  always_ff @(posedge clk) begin
    if (rst || (rdy && flush)) begin
      busy  <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      // Ascending port order: the highest index lands last and wins.
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_valid[k] && busy[wbid[k]]) begin
          ready[wbid[k]]    <= 1'b1;
          e_value[wbid[k]]  <= wbval[k];
          e_target[wbid[k]] <= wbtgt[k];
        end
      end
      if (issue_fire) begin
        busy[tail]          <= 1'b1;
        ready[tail]         <= issue_instant;
        e_type[tail]        <= issue_type;
        e_rd[tail]          <= issue_rd;
        e_pc[tail]          <= issue_pc;
        e_value[tail]       <= issue_instant_value;
        e_target[tail]      <= '0;
        e_pred_taken[tail]  <= issue_pred_taken;
        e_pred_target[tail] <= issue_pred_target;
        tail                <= tail + ROB_W'(1);
      end
      if (commit_fire) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= head + ROB_W'(1);
      end
      case ({issue_fire, commit_fire})
        2'b10:   count <= count + (ROB_W+1)'(1);
        2'b01:   count <= count - (ROB_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  logic [ROB_W-1:0] qid  [2];
  logic             qrdy [2];
  logic [XLEN-1:0]  qval [2];
  logic             qhit [2];
  logic [XLEN-1:0]  qhv  [2];
  assign qid[0] = q_id1;
  assign qid[1] = q_id2;

  // Priority: stored entry, then lowest-index writeback port, then decoder.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      qhit[q] = 1'b0;
      qhv[q]  = '0;
      for (int k = WB_PORTS-1; k >= 0; k--) begin
        if (wb_valid[k] && (wbid[k] == qid[q])) begin
          qhit[q] = 1'b1;
          qhv[q]  = wbval[k];
        end
      end
      qrdy[q] = ready[qid[q]];
      qval[q] = e_value[qid[q]];
      if (!ready[qid[q]]) begin
        if (qhit[q]) begin
          qrdy[q] = 1'b1;
          qval[q] = qhv[q];
        end else if (issue_fire && issue_instant && (tail == qid[q])) begin
          qrdy[q] = 1'b1;
          qval[q] = issue_instant_value;
        end
      end
    end
  end

  assign q_ready1 = qrdy[0];
  assign q_ready2 = qrdy[1];
  assign q_value1 = qval[0];
  assign q_value2 = qval[1];

`ifdef ROB_RETIRE_CNT_EN
  logic [63:0] retire_q;
  always_ff @(posedge clk) begin
    if (rst)
      retire_q <= '0;
    else if (commit_fire)
      retire_q <= retire_q + 64'd1;
  end
  assign retire_cnt = retire_q;
`else
  assign retire_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_multiport.sv
`default_nettype none
// Scoreboard bench for rob_multiport: directed issue/writeback with queued commit expectations.
module tb_rob_multiport;
  localparam int ROB_W = 4;
  localparam int WBP   = 2;
  localparam int XLEN  = 32;
  localparam logic [6:0] T_ALU = 7'h33, T_LUI = 7'h37, T_JALR = 7'h67, T_BR = 7'h63;

  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic issue_valid = 1'b0, issue_pred_taken = 1'b0;
  logic [6:0] issue_type = '0;
  logic [4:0] issue_rd = '0;
  logic [XLEN-1:0] issue_pc = '0, issue_imm = '0, issue_pred_target = '0;
  logic rob_full, commit_valid, flush, q_ready1, q_ready2;
  logic [ROB_W:0] rob_count;
  logic [ROB_W-1:0] alloc_id, head_id, commit_id, q_id1 = '0, q_id2 = '0;
  logic [WBP-1:0] wb_valid = '0;
  logic [WBP*ROB_W-1:0] wb_id = '0;
  logic [WBP*XLEN-1:0] wb_value = '0, wb_target = '0;
  logic [4:0] commit_rd;
  logic [XLEN-1:0] commit_value, q_value1, q_value2, flush_pc;
  logic [63:0] retire_cnt;

  rob_multiport #(.ROB_W(ROB_W), .WB_PORTS(WBP), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_pc(issue_pc),
    .issue_rd(issue_rd), .issue_imm(issue_imm), .issue_pred_taken(issue_pred_taken),
    .issue_pred_target(issue_pred_target),
    .rob_full(rob_full), .rob_count(rob_count), .alloc_id(alloc_id), .head_id(head_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value), .wb_target(wb_target),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_rd(commit_rd),
    .commit_value(commit_value),
    .q_id1(q_id1), .q_id2(q_id2), .q_ready1(q_ready1), .q_ready2(q_ready2),
    .q_value1(q_value1), .q_value2(q_value2),
    .flush(flush), .flush_pc(flush_pc), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROB_W-1:0] id;
    logic [4:0]       rd;
    logic [XLEN-1:0]  val;
    logic             fl;
    logic [XLEN-1:0]  fpc;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_commit(input int id, input int rd, input logic [31:0] val,
                               input logic fl, input logic [31:0] fpc);
    exp_t e;
    e.id = ROB_W'(id); e.rd = 5'(rd); e.val = val; e.fl = fl; e.fpc = fpc;
    exp_q.push_back(e);
  endtask

  // Monitor: every retirement is matched against the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (commit_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_commit: got id %0d value 0x%0h, required no commit",
                   commit_id, commit_value);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("commit_id", 64'(commit_id), 64'(e.id));
          check("commit_rd", 64'(commit_rd), 64'(e.rd));
          check("commit_value", 64'(commit_value), 64'(e.val));
          check("flush", 64'(flush), 64'(e.fl));
          check("flush_pc", 64'(flush_pc), 64'(e.fpc));
        end
      end else begin
        check("idle_flush", 64'(flush), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; issue_valid = 1'b0; wb_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_issue(input logic [6:0] t, input logic [31:0] pc, input int rd,
                           input logic [31:0] imm, input logic pt, input logic [31:0] ptg);
    issue_valid = 1'b1; issue_type = t; issue_pc = pc; issue_rd = 5'(rd);
    issue_imm = imm; issue_pred_taken = pt; issue_pred_target = ptg;
  endtask

  task automatic do_issue(input logic [6:0] t, input logic [31:0] pc, input int rd,
                          input logic [31:0] imm, input logic pt, input logic [31:0] ptg);
    set_issue(t, pc, rd, imm, pt, ptg);
    step();
    issue_valid = 1'b0;
  endtask

  task automatic set_wb(input int k, input int id, input logic [31:0] val, input logic [31:0] tgt);
    wb_valid[k] = 1'b1;
    wb_id[k*ROB_W +: ROB_W] = ROB_W'(id);
    wb_value[k*XLEN +: XLEN] = val;
    wb_target[k*XLEN +: XLEN] = tgt;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (rob_count != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(rob_count), 64'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    check("rst_full", 64'(rob_full), 64'd0);
    check("rst_count", 64'(rob_count), 64'd0);
    check("rst_alloc", 64'(alloc_id), 64'd0);
    check("rst_head", 64'(head_id), 64'd0);
    check("rst_commit_valid", 64'(commit_valid), 64'd0);
    check("rst_commit_rd", 64'(commit_rd), 64'd0);
    check("rst_commit_value", 64'(commit_value), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_flush_pc", 64'(flush_pc), 64'd0);
    check("rst_retire", retire_cnt, 64'd0);

    // Fill to capacity, try one more, then drain two writebacks per cycle.
    for (int i = 0; i < 16; i++) do_issue(T_ALU, 32'h1000 + 32'(4*i), i + 1, 0, 1'b0, 0);
    check("full_flag", 64'(rob_full), 64'd1);
    check("full_count", 64'(rob_count), 64'd16);
    check("full_alloc", 64'(alloc_id), 64'd0);
    do_issue(T_LUI, 32'h2000, 31, 32'hFFFF_F000, 1'b0, 0);
    check("drop_count", 64'(rob_count), 64'd16);
    check("drop_alloc", 64'(alloc_id), 64'd0);
    for (int j = 0; j < 8; j++) begin
      expect_commit(2*j,   2*j + 1, 32'(100 + 2*j),     1'b0, 0);
      expect_commit(2*j+1, 2*j + 2, 32'(100 + 2*j + 1), 1'b0, 0);
      set_wb(0, 2*j,   32'(100 + 2*j),     0);
      set_wb(1, 2*j+1, 32'(100 + 2*j + 1), 0);
      step();
      wb_valid = '0;
    end
    wait_empty("drain_full");

    // LUI: instant lookup, then hold with rdy low before it retires.
    do_reset();
    expect_commit(0, 5, 32'h1234_5000, 1'b0, 0);
    set_issue(T_LUI, 32'h40, 5, 32'h1234_5000, 1'b0, 0);
    q_id2 = 0;
    @(negedge clk);
    check("lut_issue_ready", 64'(q_ready2), 64'd1);
    check("lut_issue_value", 64'(q_value2), 64'h1234_5000);
    step();
    issue_valid = 1'b0;
    rdy = 1'b0;
    @(negedge clk);
    check("rdy_low_commit", 64'(commit_valid), 64'd0);
    step();
    check("rdy_low_count", 64'(rob_count), 64'd1);
    rdy = 1'b1;
    wait_empty("lui_drain");

    // Out-of-order completion, in-order commit.
    do_reset();
    expect_commit(0, 10, 32'd3, 1'b0, 0);
    expect_commit(1, 11, 32'd7, 1'b0, 0);
    do_issue(T_ALU, 32'h80, 10, 0, 1'b0, 0);
    do_issue(T_ALU, 32'h84, 11, 0, 1'b0, 0);
    set_wb(1, 1, 32'd7, 0);
    step();
    wb_valid = '0;
    check("ooo_hold_count", 64'(rob_count), 64'd2);
    set_wb(0, 0, 32'd3, 0);
    step();
    wb_valid = '0;
    wait_empty("ooo_drain");

    // Same id on both ports: port1 stored, port0 bypassed.
    do_reset();
    expect_commit(0, 1, 32'd1, 1'b0, 0);
    expect_commit(1, 2, 32'd2, 1'b0, 0);
    expect_commit(2, 3, 32'hBB, 1'b0, 0);
    for (int i = 0; i < 3; i++) do_issue(T_ALU, 32'h90, i + 1, 0, 1'b0, 0);
    set_wb(0, 2, 32'hAA, 0);
    set_wb(1, 2, 32'hBB, 0);
    q_id1 = 2;
    @(negedge clk);
    check("dual_wb_lookup_ready", 64'(q_ready1), 64'd1);
    check("dual_wb_lookup_value", 64'(q_value1), 64'hAA);
    step();
    wb_valid = '0;
    set_wb(0, 0, 32'd1, 0);
    set_wb(1, 1, 32'd2, 0);
    @(negedge clk);
    check("stored_lookup_ready", 64'(q_ready1), 64'd1);
    check("stored_lookup_value", 64'(q_value1), 64'hBB);
    step();
    wb_valid = '0;
    wait_empty("dual_drain");

    // Branch predicted taken, resolved not-taken: flush to pc+4, younger LUI discarded.
    do_reset();
    expect_commit(0, 0, 32'd0, 1'b1, 32'h104);
    do_issue(T_BR, 32'h100, 7, 32'h80, 1'b1, 32'h180);
    do_issue(T_LUI, 32'h104, 3, 32'h5000, 1'b0, 0);
    set_wb(0, 0, 32'd0, 32'h180);
    step();
    wb_valid = '0;
    wait_empty("br_flush_count");
    check("br_flush_head", 64'(head_id), 64'd0);
    check("br_flush_alloc", 64'(alloc_id), 64'd0);

    // LUI, correctly predicted branch, then mispredicted JALR.
    do_reset();
    expect_commit(0, 2, 32'h7000, 1'b0, 0);
    expect_commit(1, 0, 32'd1, 1'b0, 0);
    expect_commit(2, 1, 32'h204, 1'b1, 32'h340);
    do_issue(T_LUI, 32'h140, 2, 32'h7000, 1'b0, 0);
    do_issue(T_BR, 32'h150, 9, 32'h30, 1'b1, 32'h180);
    do_issue(T_JALR, 32'h200, 1, 0, 1'b0, 32'h300);
    set_wb(0, 1, 32'd1, 32'h180);
    set_wb(1, 2, 32'h204, 32'h340);
    step();
    wb_valid = '0;
    wait_empty("jalr_flush_count");
`ifdef ROB_RETIRE_CNT_EN
    check("retire_cnt", retire_cnt, 64'd3);
`else
    check("retire_cnt", retire_cnt, 64'd0);
`endif

    repeat (3) step();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drained: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
